// File: rtl/fd_fetch_ctrl.sv
// FAST-9 fetch sequencer: reads a candidate centre plus its 16 radius-3 circle pixels
// into register slots 0..16 and hands the set to the detector. Optional raster mode: FD_AUTOSCAN_EN.
module fd_fetch_ctrl #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned SRAM_LAT = 1,
  parameter int unsigned BORDER   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        centreX,
  input  logic [8:0]        centreY,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramRd,
  output logic [4:0]        regAddr,
  output logic              regWe,
  output logic              readen,
  input  logic              detAck,
  output logic [9:0]        curX,
  output logic [8:0]        curY
);

  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 9;
  localparam int unsigned IW  = 5;
  localparam int unsigned AW1 = ADDR_W + 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(16);
  localparam logic [XW-1:0] X_LO     = XW'(BORDER);
  localparam logic [XW-1:0] X_HI     = XW'(IMG_W - BORDER);
  localparam logic [YW-1:0] Y_LO     = YW'(BORDER);
  localparam logic [YW-1:0] Y_HI     = YW'(IMG_H - BORDER);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t            state;
  logic [IW-1:0]     rd_idx;
  logic [ADDR_W-1:0] base;
  logic [SRAM_LAT-1:0] slot_vld;
  logic [IW-1:0]     slot_idx [SRAM_LAT];

  logic              border_bad;
  logic [ADDR_W-1:0] cur_base;
  logic [IW-1:0]     next_idx;
  logic [ADDR_W-1:0] next_addr;

  // Signed linear offset of circle point k relative to the centre address.
  function automatic logic signed [AW1-1:0] circle_offset(input logic [IW-1:0] k);
    int dx;
    int dy;
    dx = 0;
    dy = 0;
    case (k)
      5'd1:  begin dx =  0; dy = -3; end
      5'd2:  begin dx =  1; dy = -3; end
      5'd3:  begin dx =  2; dy = -2; end
      5'd4:  begin dx =  3; dy = -1; end
      5'd5:  begin dx =  3; dy =  0; end
      5'd6:  begin dx =  3; dy =  1; end
      5'd7:  begin dx =  2; dy =  2; end
      5'd8:  begin dx =  1; dy =  3; end
      5'd9:  begin dx =  0; dy =  3; end
      5'd10: begin dx = -1; dy =  3; end
      5'd11: begin dx = -2; dy =  2; end
      5'd12: begin dx = -3; dy =  1; end
      5'd13: begin dx = -3; dy =  0; end
      5'd14: begin dx = -3; dy = -1; end
      5'd15: begin dx = -2; dy = -2; end
      5'd16: begin dx = -1; dy = -3; end
      default: begin dx = 0; dy = 0; end
    endcase
    return AW1'(dy * int'(IMG_W) + dx);
  endfunction

  function automatic logic [ADDR_W-1:0] centre_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ADDR_W'(int'(y) * int'(IMG_W) + int'(x));
  endfunction

  // Border test, centre base and the address of the following circle point.
  always_comb begin
    border_bad = (curX < X_LO) || (curX >= X_HI) || (curY < Y_LO) || (curY >= Y_HI);
    cur_base   = centre_addr(curX, curY);
    next_idx   = rd_idx + IW'(1);
    next_addr  = ADDR_W'({1'b0, base} + AW1'(circle_offset(next_idx)));
  end

`ifdef FD_AUTOSCAN_EN
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - BORDER - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - BORDER - 1);

  logic          scan_last;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;

  // Raster successor of the current centre.
  always_comb begin
    scan_last = (curX == X_LAST) && (curY == Y_LAST);
    scan_x    = (curX == X_LAST) ? X_LO : curX + XW'(1);
    scan_y    = (curX == X_LAST) ? curY + YW'(1) : curY;
  end
`endif

  // Slot pipeline: read index and valid travel alongside the SRAM latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_vld <= '0;
      for (int s = 0; s < SRAM_LAT; s++) slot_idx[s] <= '0;
    end else begin
      slot_vld[0] <= sramRd;
      slot_idx[0] <= sramRd ? rd_idx : '0;
      for (int s = 1; s < SRAM_LAT; s++) begin
        slot_vld[s] <= slot_vld[s-1];
        slot_idx[s] <= slot_idx[s-1];
      end
    end
  end

  assign regWe   = slot_vld[SRAM_LAT-1];
  assign regAddr = slot_idx[SRAM_LAT-1];

  // Sequencer with registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      sramAddr <= '0;
      sramRd   <= 1'b0;
      readen   <= 1'b0;
      curX     <= '0;
      curY     <= '0;
      rd_idx   <= '0;
      base     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // done cycle still counts as busy; a start seen then is dropped
          if (start && !done) begin
            busy  <= 1'b1;
            state <= CHECK;
`ifdef FD_AUTOSCAN_EN
            curX  <= X_LO;
            curY  <= Y_LO;
`else
            curX  <= centreX;
            curY  <= centreY;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        CHECK: begin
          if (border_bad) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            base     <= cur_base;
            sramAddr <= cur_base;
            sramRd   <= 1'b1;
            rd_idx   <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (rd_idx == LAST_IDX) begin
            sramRd   <= 1'b0;
            sramAddr <= '0;
            rd_idx   <= '0;
            state    <= DRAIN;
          end else begin
            rd_idx   <= next_idx;
            sramAddr <= next_addr;
          end
        end
        DRAIN: begin
          if (regWe && (regAddr == LAST_IDX)) begin
            readen <= 1'b1;
            state  <= VALID;
          end
        end
        VALID: begin
          if (detAck) begin
            readen <= 1'b0;
`ifdef FD_AUTOSCAN_EN
            if (scan_last) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              curX     <= scan_x;
              curY     <= scan_y;
              base     <= centre_addr(scan_x, scan_y);
              sramAddr <= centre_addr(scan_x, scan_y);
              sramRd   <= 1'b1;
              rd_idx   <= '0;
              state    <= ISSUE;
            end
`else
            done  <= 1'b1;
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
